// File: rtl/seven_seg_scanner_if.sv
// Interface bundling the load/staging controls and the display pins of
// seven_seg_scanner. The master side drives value/control, the slave (scanner)
// drives pending and the active-low display pins.
interface seven_seg_scanner_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   value;
    logic [NUM_DIGITS-1:0]     dp_in;
    logic                      hex_en;
    logic                      lz_suppress;
    logic                      pending;
    logic [NUM_DIGITS-1:0]     an;
    logic [6:0]                seg;
    logic                      dp_n;

    modport master (
        output load, value, dp_in, hex_en, lz_suppress,
        input  pending, an, seg, dp_n
    );

    modport slave (
        input  load, value, dp_in, hex_en, lz_suppress,
        output pending, an, seg, dp_n
    );
endinterface

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed common-anode 7-segment driver. A double-buffered nibble word
// (staging -> display, swapped only at frame boundaries) is scanned one digit per
// refresh slot, with a short all-off blanking gap at the start of every slot.
// All display pins are registered and reflect the previous cycle's scan state.
module seven_seg_scanner #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned BLANK_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    seven_seg_scanner_if.slave bus
);

    localparam int unsigned DivW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned ValW = 4 * NUM_DIGITS;

    localparam logic [DivW-1:0] DivLast = DivW'(REFRESH_DIV - 1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(NUM_DIGITS - 1);
    localparam logic [6:0]      SegOff  = 7'h7F;

    // Active-low a..g glyph for one nibble; 10..15 blank unless hex is enabled.
    function automatic logic [6:0] glyph(input logic [3:0] nib, input logic hex);
        logic [6:0] g;
        case (nib)
            4'h0:    g = 7'h01;
            4'h1:    g = 7'h4F;
            4'h2:    g = 7'h12;
            4'h3:    g = 7'h06;
            4'h4:    g = 7'h4C;
            4'h5:    g = 7'h24;
            4'h6:    g = 7'h20;
            4'h7:    g = 7'h0F;
            4'h8:    g = 7'h00;
            4'h9:    g = 7'h04;
            4'hA:    g = hex ? 7'h08 : SegOff;
            4'hB:    g = hex ? 7'h60 : SegOff;
            4'hC:    g = hex ? 7'h31 : SegOff;
            4'hD:    g = hex ? 7'h42 : SegOff;
            4'hE:    g = hex ? 7'h30 : SegOff;
            default: g = hex ? 7'h38 : SegOff;
        endcase
        return g;
    endfunction

    // Scan state
    logic            run_q;
    logic [DivW-1:0] div_cnt_q, div_cnt_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic            wrap;
    logic            frame_end;

    // Double buffer
    logic [ValW-1:0]       staging_val_q;
    logic [NUM_DIGITS-1:0] staging_dp_q;
    logic [ValW-1:0]       disp_val_q;
    logic [NUM_DIGITS-1:0] disp_dp_q;
    logic                  pending_q;

    // Per-digit selection
    logic [NUM_DIGITS-1:0] lz_mask;
    logic                  zero_run;
    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic                  cur_lz;
    logic [NUM_DIGITS-1:0] an_sel;
    logic                  slot_active;

    // Registered outputs
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_n_q, dp_n_d;

    // Release synchroniser: reset asserts asynchronously, scanning starts one
    // clock after rst_n rises so the counters never see a partial release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    // Refresh divider and digit index next-state
    always_comb begin
        wrap      = run_q && (div_cnt_q == DivLast);
        frame_end = wrap && (idx_q == IdxLast);
        div_cnt_d = div_cnt_q;
        idx_d     = idx_q;
        if (run_q) begin
            div_cnt_d = wrap ? '0 : div_cnt_q + DivW'(1);
        end
        if (wrap) begin
            idx_d = (idx_q == IdxLast) ? '0 : idx_q + IdxW'(1);
        end
    end

    // Divider and digit index registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
            idx_q     <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            idx_q     <= idx_d;
        end
    end

    // Staging/display buffers: display only changes at a frame boundary, and a
    // load landing on the boundary cycle bypasses staging straight to display.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            staging_val_q <= '0;
            staging_dp_q  <= '0;
            disp_val_q    <= '0;
            disp_dp_q     <= '0;
            pending_q     <= 1'b0;
        end else begin
            if (bus.load && frame_end) begin
                staging_val_q <= bus.value;
                staging_dp_q  <= bus.dp_in;
                disp_val_q    <= bus.value;
                disp_dp_q     <= bus.dp_in;
                pending_q     <= 1'b0;
            end else if (bus.load) begin
                staging_val_q <= bus.value;
                staging_dp_q  <= bus.dp_in;
                pending_q     <= 1'b1;
            end else if (frame_end && pending_q) begin
                disp_val_q <= staging_val_q;
                disp_dp_q  <= staging_dp_q;
                pending_q  <= 1'b0;
            end
        end
    end

    // Leading-zero mask: bit k set when display nibbles k..top are all zero
    always_comb begin
        zero_run = 1'b1;
        lz_mask  = '0;
        for (int k = int'(NUM_DIGITS) - 1; k >= 0; k--) begin
            zero_run   = zero_run & (disp_val_q[4*k +: 4] == 4'd0);
            lz_mask[k] = zero_run;
        end
    end

    // Select the nibble, decimal point and anode for the digit being scanned
    always_comb begin
        cur_nib = '0;
        cur_dp  = 1'b0;
        cur_lz  = 1'b0;
        an_sel  = '0;
        for (int k = 0; k < int'(NUM_DIGITS); k++) begin
            if (idx_q == IdxW'(k)) begin
                cur_nib   = disp_val_q[4*k +: 4];
                cur_dp    = disp_dp_q[k];
                // Digit 0 is never suppressed so an all-zero word still shows '0'
                cur_lz    = (k != 0) && lz_mask[k];
                an_sel[k] = 1'b1;
            end
        end
    end

    // Output next-state: blank during the gap, else drive the selected digit
    always_comb begin
        slot_active = run_q && (int'(div_cnt_q) >= int'(BLANK_CYCLES));
        an_d        = '1;
        seg_d       = SegOff;
        dp_n_d      = 1'b1;
        if (slot_active) begin
            an_d   = ~an_sel;
            seg_d  = (bus.lz_suppress && cur_lz) ? SegOff : glyph(cur_nib, bus.hex_en);
            dp_n_d = ~cur_dp;
        end
    end

    // Display pin registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_q   <= '1;
            seg_q  <= SegOff;
            dp_n_q <= 1'b1;
        end else begin
            an_q   <= an_d;
            seg_q  <= seg_d;
            dp_n_q <= dp_n_d;
        end
    end

    assign bus.an      = an_q;
    assign bus.seg     = seg_q;
    assign bus.dp_n    = dp_n_q;
    assign bus.pending = pending_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench for seven_seg_scanner (4 digits, 8 clocks/slot, 2 blank).
// Stimulus pushes the expected first-cycle pin state of each slot of a frame;
// the monitor pops one entry at every blank->active anode transition.
module tb_seven_seg_scanner;

    localparam int unsigned ND = 4;
    localparam int unsigned RD = 8;
    localparam int unsigned BC = 2;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp_n;
    } slot_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seven_seg_scanner_if #(.NUM_DIGITS(ND)) bus ();

    seven_seg_scanner #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD),
        .BLANK_CYCLES(BC)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    slot_t      exp_q[$];
    int         errors = 0;
    int         checks = 0;
    logic [3:0] mon_prev = 4'hF;

    task automatic check_eq(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    task automatic push(input logic [3:0] an, input logic [6:0] seg, input logic dp_n);
        slot_t s;
        s.an   = an;
        s.seg  = seg;
        s.dp_n = dp_n;
        exp_q.push_back(s);
    endtask

    // Expected frame, digit 0 first; dpn holds active-low dp per digit
    task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                              input logic [6:0] s3, input logic [3:0] dpn);
        push(4'b1110, s0, dpn[0]);
        push(4'b1101, s1, dpn[1]);
        push(4'b1011, s2, dpn[2]);
        push(4'b0111, s3, dpn[3]);
    endtask

    // Return at the negedge where digit k's slot first turns on
    task automatic wait_slot_start(input int k);
        logic [3:0] pat;
        logic [3:0] prev;
        int         n;
        bit         done;
        pat  = ~(4'b0001 << k);
        prev = bus.an;
        n    = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (bus.an == pat && prev == 4'hF) begin
                done = 1'b1;
            end else begin
                prev = bus.an;
                n++;
                if (n > 200) begin
                    checks++;
                    errors++;
                    $display("FAIL timeout: slot %0d start never seen, an=%b", k, bus.an);
                    done = 1'b1;
                end
            end
        end
    endtask

    // Park inside digit 3's slot: the next slot start is digit 0 of the next frame
    task automatic align();
        wait_slot_start(3);
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] dp);
        bus.value  = v;
        bus.dp_in  = dp;
        bus.load   = 1'b1;
        @(posedge clk);
        #1;
        bus.load   = 1'b0;
    endtask

    // Monitor: compare the first active cycle of each slot against the queue
    initial begin
        slot_t got;
        slot_t want;
        forever begin
            @(negedge clk);
            if (bus.an != 4'hF && mon_prev == 4'hF && exp_q.size() > 0) begin
                want     = exp_q.pop_front();
                got.an   = bus.an;
                got.seg  = bus.seg;
                got.dp_n = bus.dp_n;
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("FAIL slot: an=%b seg=%h dp_n=%b, want an=%b seg=%h dp_n=%b",
                             got.an, got.seg, got.dp_n, want.an, want.seg, want.dp_n);
                end
            end
            mon_prev = bus.an;
        end
    end

    initial begin
        bus.load        = 1'b0;
        bus.value       = '0;
        bus.dp_in       = '0;
        bus.hex_en      = 1'b0;
        bus.lz_suppress = 1'b0;

        // T1: reset values, then first active slot on the 4th edge after release
        #23;
        check_eq("t1_rst_an", 16'(bus.an), 16'hF);
        check_eq("t1_rst_seg", 16'(bus.seg), 16'h7F);
        check_eq("t1_rst_dp_n", 16'(bus.dp_n), 16'h1);
        check_eq("t1_rst_pending", 16'(bus.pending), 16'h0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("t1_edge3_an", 16'(bus.an), 16'hF);
        @(posedge clk);
        #1;
        check_eq("t1_edge4_an", 16'(bus.an), 16'hE);
        check_eq("t1_edge4_seg", 16'(bus.seg), 16'h01);

        // T2: mid-frame load with dp on digit 2
        wait_slot_start(1);
        do_load(16'h1234, 4'b0100);
        check_eq("t2_pending_set", 16'(bus.pending), 16'h1);
        align();
        check_eq("t2_pending_hold", 16'(bus.pending), 16'h1);
        push_frame(7'h4C, 7'h06, 7'h12, 7'h4F, 4'b1011);
        wait_slot_start(0);
        check_eq("t2_pending_clear", 16'(bus.pending), 16'h0);

        // T3: hex digits blank in BCD mode, glyphs once hex_en goes high
        wait_slot_start(1);
        do_load(16'hABCD, 4'b0000);
        align();
        push_frame(7'h7F, 7'h7F, 7'h7F, 7'h7F, 4'b1111);
        align();
        bus.hex_en = 1'b1;
        push_frame(7'h42, 7'h31, 7'h60, 7'h08, 4'b1111);

        // T4: leading-zero suppression
        bus.lz_suppress = 1'b1;
        wait_slot_start(1);
        do_load(16'h0050, 4'b0000);
        align();
        push_frame(7'h01, 7'h24, 7'h7F, 7'h7F, 4'b1111);
        wait_slot_start(1);
        do_load(16'h0000, 4'b0000);
        align();
        push_frame(7'h01, 7'h7F, 7'h7F, 7'h7F, 4'b1111);
        wait_slot_start(1);
        do_load(16'h0050, 4'b0000);
        align();
        bus.lz_suppress = 1'b0;
        push_frame(7'h01, 7'h24, 7'h01, 7'h01, 4'b1111);

        // T5: last load wins within a frame
        wait_slot_start(0);
        do_load(16'h1111, 4'b0000);
        wait_slot_start(1);
        do_load(16'h2222, 4'b0000);
        check_eq("t5_pending_two_loads", 16'(bus.pending), 16'h1);
        align();
        push_frame(7'h12, 7'h12, 7'h12, 7'h12, 4'b1111);

        // T5: load exactly on the boundary cycle (div_cnt=7, idx=3)
        wait_slot_start(3);
        repeat (4) @(posedge clk);
        #1;
        do_load(16'h5678, 4'b0001);
        check_eq("t5_boundary_pending", 16'(bus.pending), 16'h0);
        push_frame(7'h00, 7'h0F, 7'h20, 7'h24, 4'b1110);

        // T6: asynchronous reset during slot 2, away from any clock edge
        align();
        wait_slot_start(2);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6_async_an", 16'(bus.an), 16'hF);
        check_eq("t6_async_seg", 16'(bus.seg), 16'h7F);
        check_eq("t6_async_dp_n", 16'(bus.dp_n), 16'h1);
        check_eq("t6_async_pending", 16'(bus.pending), 16'h0);
        check_eq("t6_queue_drained", 16'(exp_q.size()), 16'h0);
        #20;
        rst_n = 1'b1;
        push(4'b1110, 7'h01, 1'b1);
        wait_slot_start(1);
        check_eq("t6_restart_consumed", 16'(exp_q.size()), 16'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
